// File: rtl/la_regbank_sequencer_if.sv
// ---------------------------------------------------------------------------
// la_regbank_sequencer_if: command/readback bundle for the LA register bank.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface la_regbank_sequencer_if #(
  parameter int BITS = 16
);
  logic [15:0]     cmd_i;
  logic [BITS-1:0] data_i;
  logic            cmd_vld_i;
  logic            pace_i;
  logic            ack_i;
  logic [BITS-1:0] out_data_o;
  logic [7:0]      out_idx_o;
  logic            out_vld_o;
  logic [1:0]      state_o;
  logic            done_o;
  logic            err_o;

  modport master (
    output cmd_i, data_i, cmd_vld_i, pace_i, ack_i,
    input  out_data_o, out_idx_o, out_vld_o, state_o, done_o, err_o
  );

  modport slave (
    input  cmd_i, data_i, cmd_vld_i, pace_i, ack_i,
    output out_data_o, out_idx_o, out_vld_o, state_o, done_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/la_regbank_sequencer.sv
// ---------------------------------------------------------------------------
// la_regbank_sequencer: LA register bank with XOR checksum and paced readback.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module la_regbank_sequencer #(
  parameter int BITS  = 16,
  parameter int NREGS = 4,
  parameter int DELAY = 2000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  la_regbank_sequencer_if.slave bus
);
  localparam int DLY = (DELAY < 1) ? 1 : DELAY;
  localparam int CW  = $clog2(DLY + 1);

  localparam logic [15:0] CMD_OPEN  = 16'hAB00;
  localparam logic [15:0] CMD_RUN   = 16'hAB40;
  localparam logic [15:0] CMD_ABORT = 16'hABFF;
  localparam logic [7:0]  CMD_WR_HI = 8'hA0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_PROC  = 2'b11
  } state_e;

  state_e          state_q;
  logic            cmd_q;
  logic            ack_q;
  logic [BITS-1:0] regs_q [NREGS];
  logic [BITS-1:0] chk_q;
  logic [7:0]      ptr_q;
  logic [7:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  logic            pace_q;
  logic [BITS-1:0] out_data_q;
  logic            out_vld_q;
  logic            done_q;
  logic            err_q;

  logic            cmd_acc;
  logic            ack_acc;
  logic            adv;
  logic [7:0]      idx_d;
  logic [BITS-1:0] proc_word;
  logic [BITS-1:0] next_word;

  assign cmd_acc = bus.cmd_vld_i & ~cmd_q;
  assign ack_acc = bus.ack_i & ~ack_q;
  assign adv     = pace_q ? ack_acc : (cnt_q == '0);
  assign idx_d   = idx_q + 8'd1;

  // Index NREGS falls through to the checksum word.
  always_comb begin
    proc_word = '0;
    next_word = chk_q;
    for (int i = 0; i < NREGS; i++) begin
      if (ptr_q == 8'(i)) proc_word = regs_q[i];
      if (idx_d == 8'(i)) next_word = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 1'b0;
      ack_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      chk_q      <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      pace_q     <= 1'b0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cmd_q  <= bus.cmd_vld_i;
      ack_q  <= bus.ack_i;
      done_q <= 1'b0;
      if (cmd_acc && bus.cmd_i == CMD_ABORT) begin
        state_q   <= S_IDLE;
        out_vld_q <= 1'b0;
      end else begin
        if (cmd_acc) begin
          case (state_q)
            S_IDLE: begin
              if (bus.cmd_i == CMD_OPEN) begin
                state_q <= S_WRITE;
                for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
                chk_q   <= '0;
                err_q   <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end
            S_WRITE: begin
              if (bus.cmd_i[15:8] == CMD_WR_HI) begin
                if (bus.cmd_i[7:0] < 8'(NREGS)) begin
                  for (int i = 0; i < NREGS; i++)
                    if (bus.cmd_i[7:0] == 8'(i)) regs_q[i] <= bus.data_i;
                end else begin
                  err_q <= 1'b1;
                end
              end else if (bus.cmd_i == CMD_RUN) begin
                state_q <= S_PROC;
                ptr_q   <= '0;
                chk_q   <= '0;
              end else begin
                err_q <= 1'b1;
              end
            end
            // PROC/READ keep running; a stray command only flags an error.
            default: err_q <= 1'b1;
          endcase
        end

        case (state_q)
          S_PROC: begin
            // NREGS folding cycles, then one cycle to present word 0.
            if (ptr_q == 8'(NREGS)) begin
              state_q    <= S_READ;
              idx_q      <= '0;
              out_data_q <= regs_q[0];
              out_vld_q  <= 1'b1;
              cnt_q      <= CW'(DLY - 1);
              pace_q     <= bus.pace_i;
            end else begin
              chk_q <= chk_q ^ proc_word;
              ptr_q <= ptr_q + 8'd1;
            end
          end
          S_READ: begin
            if (adv) begin
              if (idx_q == 8'(NREGS)) begin
                out_vld_q <= 1'b0;
                done_q    <= 1'b1;
                state_q   <= S_IDLE;
              end else begin
                idx_q      <= idx_d;
                out_data_q <= next_word;
                cnt_q      <= CW'(DLY - 1);
              end
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.out_data_o = out_data_q;
  assign bus.out_idx_o  = idx_q;
  assign bus.out_vld_o  = out_vld_q;
  assign bus.state_o    = state_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_la_regbank_sequencer.sv
// ---------------------------------------------------------------------------
// tb_la_regbank_sequencer: randomized scoreboard bench for la_regbank_sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_la_regbank_sequencer;
  localparam int BITS  = 16;
  localparam int NREGS = 4;
  localparam int DELAY = 5;
  localparam logic [15:0] OPEN  = 16'hAB00;
  localparam logic [15:0] RUN   = 16'hAB40;
  localparam logic [15:0] ABORT = 16'hABFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  la_regbank_sequencer_if #(.BITS(BITS)) bus();

  la_regbank_sequencer #(.BITS(BITS), .NREGS(NREGS), .DELAY(DELAY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              idx;
    logic [BITS-1:0] data;
  } word_t;

  word_t           sb[$];
  int              n_chk = 0;
  int              n_fail = 0;
  int              done_cnt = 0;
  int              hold = 0;
  int              prev_idx = 0;
  bit              prev_vld = 1'b0;
  bit              mon_timed = 1'b0;
  bit              mon_skip = 1'b0;

  // Reference model: register contents, error flag, state code.
  logic [BITS-1:0] m_regs [NREGS];
  logic [1:0]      m_state;
  bit              m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic end_word();
    if (mon_timed && !mon_skip) check("timed_hold_cycles", hold, DELAY);
  endtask

  // Monitor: every newly presented word is popped from the scoreboard.
  always @(negedge clk) begin
    if (bus.out_vld_o) begin
      if (!prev_vld || int'(bus.out_idx_o) != prev_idx) begin
        if (prev_vld) end_word();
        if (sb.size() == 0) begin
          check("unexpected_word_idx", bus.out_idx_o, 32'hFFFF_FFFF);
        end else begin
          word_t e;
          e = sb.pop_front();
          check("word_idx", bus.out_idx_o, e.idx);
          check("word_data", bus.out_data_o, e.data);
        end
        hold = 1;
      end else begin
        hold++;
      end
    end else if (prev_vld) begin
      end_word();
    end
    if (bus.done_o) done_cnt++;
    prev_vld = bus.out_vld_o;
    prev_idx = int'(bus.out_idx_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_err   = 1'b0;
    m_state = 2'b00;
  endtask

  task automatic do_cmd(input logic [15:0] c, input logic [BITS-1:0] d);
    bus.cmd_i     = c;
    bus.data_i    = d;
    bus.cmd_vld_i = 1'b1;
    if (c == ABORT) begin
      m_state = 2'b00;
    end else if (m_state == 2'b00 && c == OPEN) begin
      m_state = 2'b01;
      foreach (m_regs[i]) m_regs[i] = '0;
      m_err = 1'b0;
    end else if (m_state == 2'b01 && c[15:8] == 8'hA0) begin
      if (int'(c[7:0]) < NREGS) m_regs[int'(c[7:0])] = d;
      else m_err = 1'b1;
    end else if (m_state == 2'b01 && c == RUN) begin
      logic [BITS-1:0] x;
      x = '0;
      m_state = 2'b11;
      for (int i = 0; i < NREGS; i++) begin
        sb.push_back('{idx: i, data: m_regs[i]});
        x = x ^ m_regs[i];
      end
      sb.push_back('{idx: NREGS, data: x});
    end else begin
      m_err = 1'b1;
    end
    tick();
    bus.cmd_vld_i = 1'b0;
    check("state_after_cmd", bus.state_o, m_state);
    check("err_after_cmd", bus.err_o, m_err);
    tick();
  endtask

  task automatic write_random(input int n);
    for (int k = 0; k < n; k++) begin
      int a;
      a = $urandom_range(0, NREGS);
      do_cmd(16'hA000 | 16'(a), BITS'($urandom));
    end
  endtask

  task automatic write_fixed();
    do_cmd(16'hA000, 16'h1111);
    do_cmd(16'hA001, 16'h2222);
    do_cmd(16'hA002, 16'h4444);
    do_cmd(16'hA003, 16'h8888);
  endtask

  // Issues RUN (two edges consumed by do_cmd) and checks RUN->valid latency.
  task automatic start_run(input bit paced);
    int lat;
    bus.pace_i = paced;
    mon_timed  = !paced;
    do_cmd(RUN, '0);
    lat = 1;
    while (!bus.out_vld_o && lat < 60) begin
      tick();
      lat++;
    end
    check("run_to_valid_latency", lat, NREGS + 1);
    m_state = 2'b10;
    check("state_read", bus.state_o, 2'b10);
    bus.pace_i = !paced;
  endtask

  task automatic wait_idx(input int w);
    int t;
    t = 0;
    while (int'(bus.out_idx_o) != w && t < 200) begin
      tick();
      t++;
    end
    check("wait_idx_reached", bus.out_idx_o, w);
  endtask

  task automatic run_pass(input bit paced, input int first_hold);
    int d0;
    int t;
    start_run(paced);
    d0 = done_cnt;
    if (paced) begin
      for (int w = 0; w <= NREGS; w++) begin
        int gap;
        int h;
        gap = (first_hold == 30) ? 10 : $urandom_range(1, 12);
        h   = (w == 0) ? first_hold : $urandom_range(1, 4);
        repeat (gap) tick();
        check("paced_idx_before_ack", bus.out_idx_o, w);
        bus.ack_i = 1'b1;
        repeat (h) tick();
        bus.ack_i = 1'b0;
        if (w < NREGS) check("paced_idx_after_ack", bus.out_idx_o, w + 1);
      end
    end
    t = 0;
    while (done_cnt == d0 && t < (NREGS + 1) * DELAY + 40) begin
      if (!paced) bus.ack_i = 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    bus.ack_i = 1'b0;
    repeat (3) tick();
    m_state = 2'b00;
    check("done_pulses", done_cnt, d0 + 1);
    check("state_after_done", bus.state_o, 2'b00);
    check("vld_after_done", bus.out_vld_o, 1'b0);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.cmd_i     = '0;
    bus.data_i    = '0;
    bus.cmd_vld_i = 1'b0;
    bus.pace_i    = 1'b0;
    bus.ack_i     = 1'b0;
    model_reset();

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_state", bus.state_o, 2'b00);
    check("reset_vld", bus.out_vld_o, 1'b0);
    check("reset_err", bus.err_o, 1'b0);
    check("reset_done", bus.done_o, 1'b0);
    check("reset_idx", bus.out_idx_o, 0);
    check("reset_data", bus.out_data_o, 0);
    rst_n = 1'b1;
    tick();

    // Fixed-data timed and paced passes.
    do_cmd(OPEN, '0);
    write_fixed();
    run_pass(1'b0, 1);
    do_cmd(OPEN, '0);
    write_fixed();
    run_pass(1'b1, 30);

    // Protocol errors.
    do_cmd(OPEN, '0);
    write_random(4);
    do_cmd(16'hA007, 16'hDEAD);
    do_cmd(16'h5A5A, 16'h0);
    run_pass(1'b0, 1);
    do_cmd(RUN, '0);
    do_cmd(16'hA001, 16'h1);
    do_cmd(OPEN, '0);
    do_cmd(OPEN, '0);
    do_cmd(ABORT, '0);

    // Randomized passes.
    for (int p = 0; p < 8; p++) begin
      do_cmd(OPEN, '0);
      write_random($urandom_range(0, 6));
      run_pass(1'($urandom_range(0, 1)), $urandom_range(1, 5));
    end

    // ABORT during word 2 of a timed read.
    do_cmd(OPEN, '0);
    write_random(4);
    start_run(1'b0);
    wait_idx(2);
    mon_skip = 1'b1;
    d0 = done_cnt;
    do_cmd(ABORT, '0);
    check("abort_vld", bus.out_vld_o, 1'b0);
    sb.delete();
    repeat (10) tick();
    check("abort_no_done", done_cnt, d0);
    mon_skip = 1'b0;

    // ABORT coinciding with an ack edge in a paced read.
    do_cmd(OPEN, '0);
    write_random(3);
    start_run(1'b1);
    repeat (3) tick();
    mon_skip  = 1'b1;
    d0        = done_cnt;
    bus.ack_i = 1'b1;
    do_cmd(ABORT, '0);
    bus.ack_i = 1'b0;
    check("abort_ack_vld", bus.out_vld_o, 1'b0);
    check("abort_ack_idx", bus.out_idx_o, 0);
    sb.delete();
    repeat (5) tick();
    check("abort_ack_no_done", done_cnt, d0);
    mon_skip = 1'b0;

    // Command strobe held for 100 cycles executes once.
    bus.cmd_i     = OPEN;
    bus.cmd_vld_i = 1'b1;
    repeat (100) tick();
    bus.cmd_vld_i = 1'b0;
    tick();
    m_state = 2'b01;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_err = 1'b0;
    check("held_open_state", bus.state_o, 2'b01);
    check("held_open_err", bus.err_o, 1'b0);
    do_cmd(ABORT, '0);

    // Reset mid-read with err_o set.
    do_cmd(OPEN, '0);
    write_random(4);
    start_run(1'b0);
    wait_idx(1);
    do_cmd(16'h1234, '0);
    mon_skip = 1'b1;
    d0       = done_cnt;
    rst_n    = 1'b0;
    tick();
    check("midread_reset_state", bus.state_o, 2'b00);
    check("midread_reset_vld", bus.out_vld_o, 1'b0);
    check("midread_reset_err", bus.err_o, 1'b0);
    tick();
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    repeat (8) tick();
    check("midread_reset_no_done", done_cnt, d0);
    check("midread_reset_still_idle", bus.state_o, 2'b00);
    mon_skip = 1'b0;

    // Pass after reset with no writes reads back zeros.
    do_cmd(OPEN, '0);
    run_pass(1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
